// File: rtl/lifo_cmd_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lifo_cmd_pipe_pkg
//  Description : Constants shared by the LIFO command pipe and its response
//                buffer (response buffer depth and occupancy width).
//  Revision    : 1.0 - initial release
// ============================================================================
package lifo_cmd_pipe_pkg;

    // Response buffer depth; also the pop credit limit in the top.
    localparam int unsigned SKID_DEPTH = 2;
    // Width of an occupancy count covering 0..SKID_DEPTH.
    localparam int unsigned OCC_W      = 2;

endpackage
`default_nettype wire

// File: rtl/lifo_rsp_skid.sv
`default_nettype none
// ============================================================================
//  Module      : lifo_rsp_skid
//  Description : Two-entry valid/ready response buffer.  When empty, the
//                incoming word is presented directly at the output in the
//                cycle it arrives; otherwise the oldest stored word is shown.
//                Output data is forced to zero when nothing is available.
//  Revision    : 1.0 - initial release
// ============================================================================
module lifo_rsp_skid
    import lifo_cmd_pipe_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             i_vld,
    input  logic [W-1:0]     i_data,
    output logic             o_vld,
    output logic [W-1:0]     o_data,
    input  logic             i_rdy,
    output logic [OCC_W-1:0] o_occ
);

    logic [W-1:0]     slot_q [SKID_DEPTH];
    logic [W-1:0]     slot_d [SKID_DEPTH];
    logic             head_q, head_d;
    logic [OCC_W-1:0] occ_q, occ_d;

    logic             w_empty;
    logic             w_bypass;
    logic             w_store;
    logic             w_deq_slot;
    logic             w_tail;

    assign w_empty    = (occ_q == '0);
    // An arriving word consumed in the same cycle it appears never needs a slot.
    assign w_bypass   = w_empty & i_vld & i_rdy;
    assign w_store    = i_vld & ~w_bypass;
    assign w_deq_slot = ~w_empty & i_rdy;
    // Tail = head + occ (mod 2).
    assign w_tail     = head_q ^ occ_q[0];

    assign o_vld  = w_empty ? i_vld : 1'b1;
    assign o_data = !w_empty ? slot_q[head_q] : (i_vld ? i_data : '0);
    assign o_occ  = occ_q;

    // Next-state: slot write, head advance and occupancy update.
    always_comb begin
        slot_d = slot_q;
        if (w_store) begin
            slot_d[w_tail] = i_data;
        end
        head_d = w_deq_slot ? ~head_q : head_q;
        occ_d  = occ_q + {{(OCC_W-1){1'b0}}, w_store} - {{(OCC_W-1){1'b0}}, w_deq_slot};
    end

    // State register; reset empties the buffer and discards held words.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int i = 0; i < int'(SKID_DEPTH); i++) begin
                slot_q[i] <= '0;
            end
            head_q <= 1'b0;
            occ_q  <= '0;
        end else begin
            slot_q <= slot_d;
            head_q <= head_d;
            occ_q  <= occ_d;
        end
    end

    a_no_skid_overflow: assert property (@(posedge clk) disable iff (arst)
        !(w_store && (occ_q == OCC_W'(SKID_DEPTH))));

endmodule
`default_nettype wire

// File: rtl/lifo_cmd_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : lifo_cmd_pipe
//  Description : LIFO with valid/ready push, pop and response channels.
//                Holds the count, a flop-array store and a registered read
//                port feeding a two-entry response buffer.  Pops are admitted
//                only while the in-flight read plus buffered responses leave
//                room in the buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module lifo_cmd_pipe
    import lifo_cmd_pipe_pkg::*;
#(
    parameter int unsigned N      = 16,
    parameter int unsigned W      = 32,
    parameter int unsigned ADDR_W = $clog2(N),
    parameter int unsigned CNT_W  = ADDR_W + 1
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             i_push_vld,
    input  logic [W-1:0]     i_push_data,
    output logic             o_push_rdy,
    input  logic             i_pop_vld,
    output logic             o_pop_rdy,
    output logic             o_rsp_vld,
    output logic [W-1:0]     o_rsp_data,
    input  logic             i_rsp_rdy,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_empty,
    output logic             o_full
);

    typedef logic [CNT_W-1:0]  cnt_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [W-1:0]      word_t;

    localparam cnt_t c_full_cnt = cnt_t'(N);

    cnt_t  cnt_q, cnt_d;
    logic  empty_q, empty_d;
    logic  full_q, full_d;
    logic  inflight_q, inflight_d;
    word_t mem_q [N];
    word_t mem_d [N];
    word_t rd_data_q, rd_data_d;

    logic             w_push_fire;
    logic             w_pop_fire;
    addr_t            w_top_addr;
    addr_t            w_wr_addr;
    logic [OCC_W-1:0] w_skid_occ;
    logic [OCC_W-1:0] w_credit_used;

    assign o_push_rdy    = ~full_q;
    assign w_credit_used = {{(OCC_W-1){1'b0}}, inflight_q} + w_skid_occ;
    assign o_pop_rdy     = ~empty_q & (w_credit_used < OCC_W'(SKID_DEPTH));

    assign w_push_fire   = i_push_vld & o_push_rdy;
    assign w_pop_fire    = i_pop_vld & o_pop_rdy;
    assign w_top_addr    = addr_t'(cnt_q - cnt_t'(1));

    assign o_cnt   = cnt_q;
    assign o_empty = empty_q;
    assign o_full  = full_q;

    // Count next-state; empty/full flags are decoded from the next count.
    always_comb begin
        cnt_d = cnt_q;
        unique case ({w_push_fire, w_pop_fire})
            2'b10:   cnt_d = cnt_q + cnt_t'(1);
            2'b01:   cnt_d = cnt_q - cnt_t'(1);
            default: cnt_d = cnt_q;
        endcase
        empty_d    = (cnt_d == '0);
        full_d     = (cnt_d == c_full_cnt);
        inflight_d = w_pop_fire;
    end

    // Store write and read-port capture; a simultaneous push replaces the
    // top word after the old top has been read out.
    always_comb begin
        mem_d     = mem_q;
        w_wr_addr = w_pop_fire ? w_top_addr : addr_t'(cnt_q);
        if (w_push_fire) begin
            mem_d[w_wr_addr] = i_push_data;
        end
        rd_data_d = w_pop_fire ? mem_q[w_top_addr] : rd_data_q;
    end

    // Control state register.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            cnt_q      <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            inflight_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            inflight_q <= inflight_d;
        end
    end

    // Data path registers are left unreset; validity is tracked by the control state.
    always_ff @(posedge clk) begin
        mem_q     <= mem_d;
        rd_data_q <= rd_data_d;
    end

    lifo_rsp_skid #(
        .W (W)
    ) u_rsp_skid (
        .clk    (clk),
        .arst   (arst),
        .i_vld  (inflight_q),
        .i_data (rd_data_q),
        .o_vld  (o_rsp_vld),
        .o_data (o_rsp_data),
        .i_rdy  (i_rsp_rdy),
        .o_occ  (w_skid_occ)
    );

    a_not_full_and_empty: assert property (@(posedge clk) disable iff (arst)
        !(full_q && empty_q));

    a_cnt_in_range: assert property (@(posedge clk) disable iff (arst)
        (cnt_q <= c_full_cnt));

endmodule
`default_nettype wire
